// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, register-zero id, opcode encodings and ID/EX record types.
package cpu_pkg;
  localparam int OPC_W = 4;
  localparam int REG_W = 4;
  localparam int DATA_W = 16;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_LW  = 4'h8,
    OP_SW  = 4'h9
  } opcode_e;
  typedef enum logic {RUN, BUBBLE} state_e;
  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  src1;
    logic [REG_W-1:0]  src2;
    logic [REG_W-1:0]  dst;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
  } ex_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard between the load held in EX and the instruction in ID.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_dst,
  output logic             hazard
);
  assign hazard = id_valid && ex_valid && ex_mem_read && ex_reg_write && ex_dst != REG_ZERO &&
                  (ex_dst == id_src1 || ex_dst == id_src2);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble, flush and saturating stall count.
// Define WB_BYPASS_EN to forward same-cycle writeback data into the captured operands.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [REG_W-1:0]  id_src1,
  input  logic [REG_W-1:0]  id_src2,
  input  logic [REG_W-1:0]  id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              wb_write,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [OPC_W-1:0]  ex_opcode,
  output logic [REG_W-1:0]  ex_src1,
  output logic [REG_W-1:0]  ex_src2,
  output logic [REG_W-1:0]  ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [7:0]        stall_cnt
);
  ex_t ex_q, ex_d, cap;
  state_e state_q, state_d;
  logic [7:0] stall_d;
  logic [DATA_W-1:0] op_a, op_b;
  logic advance, hazard;
  hazard_detect u_hazard (
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.mem_read),
    .ex_reg_write(ex_q.reg_write),
    .ex_dst      (ex_q.dst),
    .hazard      (hazard)
  );
  assign advance = !ex_q.valid || ex_ready;
  assign id_ready = flush || (advance && !hazard);
`ifdef WB_BYPASS_EN
  assign op_a = id_src1 == REG_ZERO ? '0 : (wb_write && wb_dst == id_src1) ? wb_data : rf_data1;
  assign op_b = id_src2 == REG_ZERO ? '0 : (wb_write && wb_dst == id_src2) ? wb_data : rf_data2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_write, wb_dst, wb_data};
  assign op_a = id_src1 == REG_ZERO ? '0 : rf_data1;
  assign op_b = id_src2 == REG_ZERO ? '0 : rf_data2;
`endif
  assign cap = '{valid: id_valid, opcode: id_opcode, src1: id_src1, src2: id_src2, dst: id_dst,
                 reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write,
                 a: op_a, b: op_b, imm: id_imm};
  always_comb begin
    ex_d = ex_q;
    stall_d = stall_cnt;
    state_d = RUN;
    if (flush) ex_d = '0;
    else if (advance && hazard) begin
      ex_d = '0;
      stall_d = stall_cnt == 8'hFF ? stall_cnt : stall_cnt + 8'd1;
      state_d = state_q == RUN ? BUBBLE : RUN;
    end else if (advance) ex_d = cap;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      stall_cnt <= '0;
      state_q <= RUN;
    end else begin
      ex_q <= ex_d;
      stall_cnt <= stall_d;
      state_q <= state_d;
    end
  end
  assign ex_valid = ex_q.valid;
  assign ex_opcode = ex_q.opcode;
  assign ex_src1 = ex_q.src1;
  assign ex_src2 = ex_q.src2;
  assign ex_dst = ex_q.dst;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_a = ex_q.a;
  assign ex_b = ex_q.b;
  assign ex_imm = ex_q.imm;
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge; rst_n  in  1  asynchronous, active-low reset.
REQ-002 SHALL have decode-side ports: id_valid in 1; id_ready out 1; id_opcode in 4; id_src1, id_src2, id_dst in 4 each; id_reg_write, id_mem_read, id_mem_write in 1 each; id_imm in 16.
REQ-003 SHALL have register-file ports: rf_data1, rf_data2 in 16, read data for id_src1/id_src2.
REQ-004 SHALL have writeback ports: wb_write in 1; wb_dst in 4; wb_data in 16.
REQ-005 SHALL have control ports: flush in 1, branch kill; ex_ready in 1, downstream accept.
REQ-006 SHALL have execute-side ports: ex_valid out 1; ex_opcode out 4; ex_src1, ex_src2, ex_dst out 4; ex_reg_write, ex_mem_read, ex_mem_write out 1; ex_a, ex_b, ex_imm out 16.
REQ-007 SHALL have stall_cnt out 8, saturating count of load-use bubble cycles.

Function
REQ-008 SHALL define advance = !ex_valid | ex_ready; the output register loads only when advance=1.
REQ-009 SHALL define hazard = id_valid & ex_valid & ex_mem_read & ex_reg_write & ex_dst!=0 & (ex_dst==id_src1 | ex_dst==id_src2).
REQ-010 SHALL drive id_ready = flush | (advance & !hazard), combinationally.
REQ-011 SHALL, when flush=1, load ex_valid=0 at the next edge regardless of ex_ready, dropping the id instruction; flush overrides hazard and ex_ready.
REQ-012 SHALL, when advance & hazard & !flush, load a bubble (ex_valid=0, all control bits 0), keep id_ready=0, and increment stall_cnt, saturating at 8'hFF.
REQ-013 SHALL, when advance & !hazard & !flush, load all id_* fields and operands, with ex_valid=id_valid.
REQ-014 SHALL, when advance=0 and flush=0, hold every ex_* output unchanged.
REQ-015 SHALL capture ex_a=0 when id_src1==0 and ex_b=0 when id_src2==0, otherwise operand per REQ-021/022.
REQ-016 SHALL have a latency of one cycle from id handshake to ex_valid; maximum bubble length per load-use is one cycle.
REQ-017 SHALL use FSM states RUN and BUBBLE: RUN->BUBBLE on REQ-012 condition; BUBBLE->RUN unconditionally next cycle; flush forces RUN.

Reset
REQ-018 SHALL, on rst_n=0, asynchronously clear ex_valid, all ex_* fields, ex_a, ex_b, ex_imm and stall_cnt to 0 and set state RUN.
REQ-019 SHALL hold id_ready=1 while in reset; the first capture occurs on the first rising edge after rst_n deasserts.
REQ-020 SHALL discard any in-flight instruction when reset asserts mid-operation.

Configuration
REQ-021 SHALL, with WB_BYPASS_EN defined, capture ex_a=wb_data when wb_write & wb_dst==id_src1 & id_src1!=0 (same for ex_b/id_src2), else rf data.
REQ-022 SHALL, without WB_BYPASS_EN, capture rf_data1/rf_data2 directly, with the wb_* ports unused.

Structure
REQ-023 SHALL take opcode width, register-id width, REG_ZERO constant and opcode encodings from shared package cpu_pkg.
REQ-024 SHALL place the hazard equation in sub-module hazard_detect, purely combinational.

Verification
REQ-025 SHALL cover: ADD id_src1=2, rf_data1=16'h1234, ex_ready=1 -> next cycle ex_valid=1, ex_a=16'h1234.
REQ-026 SHALL cover: LW ex_dst=3 in EX, id_src2=3 -> id_ready=0, one bubble, stall_cnt 0->1, instruction issues the following cycle.
REQ-027 SHALL cover: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable, id_ready=0; resumes on ex_ready=1.
REQ-028 SHALL cover: flush=1 during hazard and ex_ready=0 -> next cycle ex_valid=0, state RUN, stall_cnt unchanged.
REQ-029 SHALL cover: WB_BYPASS_EN, wb_write=1, wb_dst=5, wb_data=16'hBEEF, id_src1=5, rf_data1=16'h0000 -> ex_a=16'hBEEF; id_src1=0 -> ex_a=0.
REQ-030 SHALL cover: rst_n pulsed low mid-stream with ex_valid=1 -> all outputs 0 immediately, without waiting for a clock edge.
